// File: rtl/mt_regfile.sv
// mt_regfile -- multi-hart integer register file with a per-register
// scoreboard of pending writebacks.
//
// Holds 4 harts x 31 general registers (x1..x31), each 32 bits wide.
// x0 has no storage and always reads as zero.
// Each register also has a busy bit. The busy bit is set when an instruction
// that writes the register issues, and cleared when that instruction writes back.
//
// Parameters
//   FWD_EN      1: a writeback is forwarded to the read ports in the same
//                  cycle. 0: reads return only stored state.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset; clears data and busy state
//   Wdata_ee     writeback data
//   Waddr_ee     writeback destination register (0 = no write)
//   RegWrite_ee  writeback enable
//   mhartID_ee   hart that owns the writeback
//   rd_hart      hart whose registers both read ports access
//   rs1_addr     read port 1 register address
//   rs2_addr     read port 2 register address
//   rs1_data     read port 1 data (combinational)
//   rs2_data     read port 2 data (combinational)
//   rs1_busy     read port 1 register has a pending writeback
//   rs2_busy     read port 2 register has a pending writeback
//   sb_set       issue marks sb_rd of sb_hart as pending
//   sb_hart      hart for sb_set
//   sb_rd        destination register for sb_set (0 = ignored)

module mt_regfile #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Wdata_ee,
  input  logic [4:0]  Waddr_ee,
  input  logic        RegWrite_ee,
  input  logic [1:0]  mhartID_ee,
  input  logic [1:0]  rd_hart,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        sb_set,
  input  logic [1:0]  sb_hart,
  input  logic [4:0]  sb_rd
);

  localparam int NUM_HARTS = 4;
  localparam int NUM_PORTS = 2;

  // Registers x1..x31 per hart. A reset must clear every entry at once
  // and reads are combinational, so this array is built from flops.
  logic [31:0] data_reg [NUM_HARTS][1:31];
  logic [31:1] busy_reg [NUM_HARTS];

  logic wr_fire;
  logic set_fire;

  assign wr_fire  = RegWrite_ee && (Waddr_ee != 5'd0);
  assign set_fire = sb_set && (sb_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        for (int r = 1; r < 32; r++) begin
          data_reg[h][r] <= '0;
        end
        busy_reg[h] <= '0;
      end
    end else begin
      if (wr_fire) begin
        data_reg[mhartID_ee][Waddr_ee] <= Wdata_ee;
        busy_reg[mhartID_ee][Waddr_ee] <= 1'b0;
      end
      // This assignment comes after the clear. If a new producer issues to
      // the same register at the edge where the old producer writes back,
      // the register stays busy.
      if (set_fire) begin
        busy_reg[sb_hart][sb_rd] <= 1'b1;
      end
    end
  end

  logic [4:0] rd_addr [NUM_PORTS];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rd_port
      logic        live;
      logic        bypass;
      logic [31:0] port_data;
      logic        port_busy;

      // Outputs are held at zero while reset is asserted. This also keeps
      // a writeback that is in flight during reset from being forwarded.
      assign live   = rst_n && (rd_addr[gi] != 5'd0);
      assign bypass = FWD_EN && wr_fire && (mhartID_ee == rd_hart) &&
                      (Waddr_ee == rd_addr[gi]);

      assign port_data = !live  ? 32'h0 :
                         bypass ? Wdata_ee :
                                  data_reg[rd_hart][rd_addr[gi]];

      // When the value is forwarded, the pending writeback is satisfied
      // in this cycle, so the port does not report busy.
      assign port_busy = live && !bypass && busy_reg[rd_hart][rd_addr[gi]];
    end
  endgenerate

  assign rs1_data = g_rd_port[0].port_data;
  assign rs2_data = g_rd_port[1].port_data;
  assign rs1_busy = g_rd_port[0].port_busy;
  assign rs2_busy = g_rd_port[1].port_busy;

endmodule

// File: tb/tb_mt_regfile.sv
// Testbench for mt_regfile.
// Two instances share the same inputs: dut_f has forwarding enabled and
// dut_n has it disabled. Inputs change on the falling edge of the clock.
// Combinational outputs are sampled 1 ns later, before the next rising edge.

module tb_mt_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] Wdata_ee;
  logic [4:0]  Waddr_ee;
  logic        RegWrite_ee;
  logic [1:0]  mhartID_ee;
  logic [1:0]  rd_hart;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        sb_set;
  logic [1:0]  sb_hart;
  logic [4:0]  sb_rd;

  logic [31:0] rs1_data_f, rs2_data_f, rs1_data_n, rs2_data_n;
  logic        rs1_busy_f, rs2_busy_f, rs1_busy_n, rs2_busy_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mt_regfile #(.FWD_EN(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .Wdata_ee(Wdata_ee), .Waddr_ee(Waddr_ee),
    .RegWrite_ee(RegWrite_ee), .mhartID_ee(mhartID_ee), .rd_hart(rd_hart),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data_f),
    .rs2_data(rs2_data_f), .rs1_busy(rs1_busy_f), .rs2_busy(rs2_busy_f),
    .sb_set(sb_set), .sb_hart(sb_hart), .sb_rd(sb_rd)
  );

  mt_regfile #(.FWD_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .Wdata_ee(Wdata_ee), .Waddr_ee(Waddr_ee),
    .RegWrite_ee(RegWrite_ee), .mhartID_ee(mhartID_ee), .rd_hart(rd_hart),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data_n),
    .rs2_data(rs2_data_n), .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n),
    .sb_set(sb_set), .sb_hart(sb_hart), .sb_rd(sb_rd)
  );

  // Deassert all write and set controls. Read selectors are left unchanged.
  task automatic idle_ctrl;
    RegWrite_ee = 1'b0;
    Waddr_ee    = 5'd0;
    Wdata_ee    = 32'h0;
    mhartID_ee  = 2'd0;
    sb_set      = 1'b0;
    sb_hart     = 2'd0;
    sb_rd       = 5'd0;
  endtask

  task automatic drive_write(input logic [1:0] h, input logic [4:0] a,
                             input logic [31:0] d);
    RegWrite_ee = 1'b1;
    mhartID_ee  = h;
    Waddr_ee    = a;
    Wdata_ee    = d;
  endtask

  task automatic test_reset;
    logic [129:0] obs;
    idle_ctrl();
    rd_hart  = 2'd0;
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    #2 rst_n = 1'b0;
    // A write and a set that arrive during reset must be ignored and not forwarded.
    drive_write(2'd0, 5'd3, 32'hFFFF_FFFF);
    sb_set = 1'b1; sb_hart = 2'd0; sb_rd = 5'd3;
    #1;
    checks++;
    if ({rs1_data_f, rs1_busy_f} !== 33'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: got data=%h busy=%b, want 0/0", rs1_data_f, rs1_busy_f);
    end
    @(posedge clk); #1;
    checks++;
    if ({rs1_data_f, rs1_busy_f, rs1_data_n, rs1_busy_n} !== 66'h0) begin
      errors++;
      $display("FAIL reset_write_ignored: got f=%h/%b n=%h/%b, want 0/0", rs1_data_f, rs1_busy_f, rs1_data_n, rs1_busy_n);
    end
    @(negedge clk);
    idle_ctrl();
    rst_n = 1'b1;
    for (int h = 0; h < 4; h++) begin
      for (int a = 0; a < 32; a++) begin
        rd_hart  = 2'(h);
        rs1_addr = 5'(a);
        rs2_addr = 5'(31 - a);
        #1;
        obs = {rs1_data_f, rs2_data_f, rs1_data_n, rs2_data_n,
               rs1_busy_f, rs2_busy_f};
        checks++;
        if (obs !== '0 || rs1_busy_n !== 1'b0 || rs2_busy_n !== 1'b0) begin
          errors++;
          $display("FAIL reset_read h=%0d a=%0d: got %h, want all 0", h, a, obs);
        end
      end
    end
    $display("reset: all 4 harts x 32 registers read");
  endtask

  task automatic test_write_read;
    @(negedge clk);
    drive_write(2'd2, 5'd5, 32'hDEAD_BEEF);
    rd_hart = 2'd2; rs1_addr = 5'd5; rs2_addr = 5'd5;
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if (rs1_data_n !== 32'hDEAD_BEEF || rs1_data_f !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_h2x5: got f=%h n=%h, want deadbeef", rs1_data_f, rs1_data_n);
    end
    checks++;
    if (rs2_data_f !== rs1_data_f || rs2_data_n !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL same_reg_both_ports: got rs1=%h rs2=%h, want deadbeef", rs1_data_f, rs2_data_f);
    end
    rd_hart = 2'd1;
    #1;
    checks++;
    if (rs1_data_f !== 32'h0 || rs1_data_n !== 32'h0) begin
      errors++;
      $display("FAIL other_hart_h1x5: got f=%h n=%h, want 0", rs1_data_f, rs1_data_n);
    end
    $display("write_read: hart2 x5 <= deadbeef, hart1 x5 read");
  endtask

  task automatic test_x0;
    @(negedge clk);
    drive_write(2'd0, 5'd0, 32'hFFFF_FFFF);
    sb_set = 1'b1; sb_hart = 2'd0; sb_rd = 5'd0;
    rd_hart = 2'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    checks++;
    if ({rs1_data_f, rs1_busy_f} !== 33'h0) begin
      errors++;
      $display("FAIL x0_same_cycle: got data=%h busy=%b, want 0/0", rs1_data_f, rs1_busy_f);
    end
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs1_data_f, rs1_busy_f, rs2_data_n, rs2_busy_n} !== 66'h0) begin
      errors++;
      $display("FAIL x0_after: got f=%h/%b n=%h/%b, want 0/0", rs1_data_f, rs1_busy_f, rs2_data_n, rs2_busy_n);
    end
    $display("x0: write ffffffff + sb_set to x0 ignored");
  endtask

  task automatic test_bypass;
    @(negedge clk);
    drive_write(2'd0, 5'd7, 32'h0000_1111);
    rd_hart = 2'd0; rs1_addr = 5'd0; rs2_addr = 5'd7;
    @(negedge clk);
    idle_ctrl();
    sb_set = 1'b1; sb_hart = 2'd0; sb_rd = 5'd7;
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs2_data_n, rs2_busy_n, rs2_busy_f} !== {32'h1111, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_bypass: got n=%h/%b f_busy=%b, want 1111/1/1", rs2_data_n, rs2_busy_n, rs2_busy_f);
    end
    drive_write(2'd0, 5'd7, 32'h0000_1234);
    #1;
    checks++;
    if ({rs2_data_f, rs2_busy_f} !== {32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL bypass_fwd: got %h/%b, want 1234/0", rs2_data_f, rs2_busy_f);
    end
    checks++;
    if ({rs2_data_n, rs2_busy_n} !== {32'h1111, 1'b1}) begin
      errors++;
      $display("FAIL bypass_nofwd: got %h/%b, want 1111/1", rs2_data_n, rs2_busy_n);
    end
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs2_data_f, rs2_busy_f, rs2_data_n, rs2_busy_n} !== {32'h1234, 1'b0, 32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL bypass_next: got f=%h/%b n=%h/%b, want 1234/0", rs2_data_f, rs2_busy_f, rs2_data_n, rs2_busy_n);
    end
    $display("bypass: hart0 x7 <= 1234 forwarded only when enabled");
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    idle_ctrl();
    sb_set = 1'b1; sb_hart = 2'd3; sb_rd = 5'd9;
    rd_hart = 2'd3; rs1_addr = 5'd9; rs2_addr = 5'd10;
    #1;
    checks++;
    if (rs1_busy_f !== 1'b0 || rs1_busy_n !== 1'b0) begin
      errors++;
      $display("FAIL sb_before_edge: got f=%b n=%b, want 0", rs1_busy_f, rs1_busy_n);
    end
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if (rs1_busy_f !== 1'b1 || rs1_busy_n !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_h3x9: got f=%b n=%b, want 1", rs1_busy_f, rs1_busy_n);
    end
    // A set and a clear to the same register at the same edge: the set wins.
    sb_set = 1'b1; sb_hart = 2'd3; sb_rd = 5'd9;
    drive_write(2'd3, 5'd9, 32'h99);
    #1;
    checks++;
    if ({rs1_data_f, rs1_busy_f, rs1_data_n, rs1_busy_n} !== {32'h99, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sb_collide_cycle: got f=%h/%b n=%h/%b, want 99/0 0/1", rs1_data_f, rs1_busy_f, rs1_data_n, rs1_busy_n);
    end
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs1_busy_f, rs1_busy_n, rs1_data_n} !== {1'b1, 1'b1, 32'h99}) begin
      errors++;
      $display("FAIL sb_set_wins: got busy f=%b n=%b data=%h, want 1/1/99", rs1_busy_f, rs1_busy_n, rs1_data_n);
    end
    // Set x10 and clear x9 at the same edge: both updates take effect.
    sb_set = 1'b1; sb_hart = 2'd3; sb_rd = 5'd10;
    drive_write(2'd3, 5'd9, 32'hAA);
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs1_data_n, rs1_busy_n, rs2_busy_n, rs1_busy_f, rs2_busy_f} !== {32'hAA, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sb_set_clear_diff: got x9=%h/%b x10=%b f=%b/%b, want aa/0 1 0/1", rs1_data_n, rs1_busy_n, rs2_busy_n, rs1_busy_f, rs2_busy_f);
    end
    rd_hart = 2'd2;
    #1;
    checks++;
    if ({rs1_data_n, rs1_busy_n, rs2_busy_n, rs2_busy_f} !== 35'h0) begin
      errors++;
      $display("FAIL sb_hart_indep: got h2 x9=%h/%b x10=%b/%b, want 0", rs1_data_n, rs1_busy_n, rs2_busy_n, rs2_busy_f);
    end
    rd_hart = 2'd3;
    // Clearing x9 when its busy bit is already 0 must leave it at 0.
    drive_write(2'd3, 5'd9, 32'hBB);
    @(negedge clk);
    drive_write(2'd3, 5'd10, 32'hCC);
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs1_data_n, rs1_busy_n, rs2_data_n, rs2_busy_n} !== {32'hBB, 1'b0, 32'hCC, 1'b0}) begin
      errors++;
      $display("FAIL sb_clear_alone: got x9=%h/%b x10=%h/%b, want bb/0 cc/0", rs1_data_n, rs1_busy_n, rs2_data_n, rs2_busy_n);
    end
    $display("scoreboard: hart3 x9/x10 set, collide, clear");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rd_hart = 2'd1; rs1_addr = 5'd1; rs2_addr = 5'd31;
    drive_write(2'd1, 5'd1, 32'h0101_0101);
    @(negedge clk);
    drive_write(2'd1, 5'd31, 32'h3131_3131);
    #1;
    checks++;
    if ({rs1_data_n, rs2_data_n, rs2_data_f} !== {32'h0101_0101, 32'h0, 32'h3131_3131}) begin
      errors++;
      $display("FAIL b2b_first: got n=%h/%h f2=%h, want 01010101/0 31313131", rs1_data_n, rs2_data_n, rs2_data_f);
    end
    @(negedge clk);
    drive_write(2'd1, 5'd1, 32'h0202_0202);
    #1;
    checks++;
    if ({rs1_data_f, rs1_data_n, rs2_data_n} !== {32'h0202_0202, 32'h0101_0101, 32'h3131_3131}) begin
      errors++;
      $display("FAIL b2b_second: got f1=%h n=%h/%h, want 02020202 01010101/31313131", rs1_data_f, rs1_data_n, rs2_data_n);
    end
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if ({rs1_data_n, rs2_data_n} !== {32'h0202_0202, 32'h3131_3131}) begin
      errors++;
      $display("FAIL b2b_final: got %h/%h, want 02020202/31313131", rs1_data_n, rs2_data_n);
    end
    $display("back_to_back: hart1 x1, x31, x1 consecutive writes");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_write(2'd1, 5'd4, 32'hA5A5_A5A5);
    rd_hart = 2'd1; rs1_addr = 5'd4; rs2_addr = 5'd1;
    @(negedge clk);
    idle_ctrl();
    #1;
    checks++;
    if (rs1_data_n !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL mid_pre: got %h, want a5a5a5a5", rs1_data_n);
    end
    // Drive a write and a set, then assert reset partway through the cycle.
    drive_write(2'd1, 5'd4, 32'h5A5A_5A5A);
    sb_set = 1'b1; sb_hart = 2'd1; sb_rd = 5'd4;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rs1_data_f, rs1_data_n, rs2_data_n, rs1_busy_f, rs1_busy_n} !== 98'h0) begin
      errors++;
      $display("FAIL mid_immediate: got f=%h n=%h x1=%h, want 0", rs1_data_f, rs1_data_n, rs2_data_n);
    end
    @(negedge clk);
    idle_ctrl();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({rs1_data_f, rs1_data_n, rs1_busy_f, rs1_busy_n} !== 66'h0) begin
      errors++;
      $display("FAIL mid_release: got f=%h/%b n=%h/%b, want 0/0", rs1_data_f, rs1_busy_f, rs1_data_n, rs1_busy_n);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({rs1_data_n, rs1_busy_n, rs2_data_n} !== 65'h0) begin
      errors++;
      $display("FAIL mid_after: got %h/%b x1=%h, want 0", rs1_data_n, rs1_busy_n, rs2_data_n);
    end
    $display("reset_mid: hart1 x4 cleared by async reset");
  endtask

  initial begin
    rd_hart = 2'd0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle_ctrl();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mt_regfile.md
MT_REGFILE -- requirements
Module: mt_regfile

Interface
REQ-001 Parameter FWD_EN, default 1, meaning: 1 enables same-cycle writeback-to-read bypass, 0 disables it.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Wdata_ee  input  32  writeback data from WB stage.
REQ-005 Waddr_ee  input  5  writeback destination register.
REQ-006 RegWrite_ee  input  1  writeback enable.
REQ-007 mhartID_ee  input  2  hart owning the writeback.
REQ-008 rd_hart  input  2  hart whose registers the read ports access.
REQ-009 rs1_addr  input  5  read port 1 address.
REQ-010 rs2_addr  input  5  read port 2 address.
REQ-011 rs1_data  output  32  read port 1 data, combinational.
REQ-012 rs2_data  output  32  read port 2 data, combinational.
REQ-013 rs1_busy  output  1  read port 1 register has a pending writeback.
REQ-014 rs2_busy  output  1  read port 2 register has a pending writeback.
REQ-015 sb_set  input  1  issue marks a destination register pending.
REQ-016 sb_hart  input  2  hart for sb_set.
REQ-017 sb_rd  input  5  destination register for sb_set.

Function
REQ-018 Storage: 4 harts x 31 registers (x1..x31) x 32 bits, plus 4 x 31 busy bits; x0 has no storage.
REQ-019 Write: at rising edge, RegWrite_ee=1 and Waddr_ee!=0 -> reg[mhartID_ee][Waddr_ee] <= Wdata_ee; no other register or hart is altered.
REQ-020 Write with Waddr_ee=0 updates neither data nor busy state.
REQ-021 Read: rsN_data = reg[rd_hart][rsN_addr], zero-latency combinational; rsN_addr=0 -> 32'h0, always.
REQ-022 Bypass (FWD_EN=1): RegWrite_ee=1, mhartID_ee=rd_hart, Waddr_ee=rsN_addr, rsN_addr!=0 -> rsN_data=Wdata_ee in the same cycle.
REQ-023 FWD_EN=0: read returns stored value; a write is visible to reads from the cycle after its edge.
REQ-024 Both ports addressing the same register return identical data.
REQ-025 Busy set: at edge, sb_set=1 and sb_rd!=0 -> busy[sb_hart][sb_rd] <= 1; sb_rd=0 ignored.
REQ-026 Busy clear: at edge, qualifying write (REQ-019) -> busy[mhartID_ee][Waddr_ee] <= 0.
REQ-027 Simultaneous set and clear on same hart/register: set wins, busy stays 1 (new producer issued).
REQ-028 Set and clear on different hart or register: both take effect.
REQ-029 Clear of an already-clear bit, or set of an already-set bit: no change, no error.
REQ-030 rsN_busy = busy[rd_hart][rsN_addr]; forced 0 when rsN_addr=0.
REQ-031 FWD_EN=1 and bypass condition of REQ-022 true for port N -> rsN_busy=0 that cycle.
REQ-032 Harts fully independent: no operation on one hart affects another hart's data or busy bits.

Reset
REQ-033 rst_n low: all data registers and busy bits cleared to 0 immediately, independent of clk.
REQ-034 During reset, rsN_data=0 and rsN_busy=0 for every address; writes and sets ignored.
REQ-035 Reset asserted mid-operation discards any in-flight write or set; first update after release is at the first rising edge with rst_n high.

Verification
REQ-036 Reset, then read all 4 harts x 32 regs -> every rsN_data=0, rsN_busy=0.
REQ-037 Write hart2 x5=32'hDEADBEEF; read rd_hart=2 rs1=5 -> DEADBEEF; rd_hart=1 rs1=5 -> 0.
REQ-038 Write x0=32'hFFFFFFFF with sb_set on x0 -> rs1_addr=0 reads 0, rs1_busy=0.
REQ-039 FWD_EN=1, RegWrite_ee hart0 x7=32'h1234 while rd_hart=0 rs2=7 -> rs2_data=1234, rs2_busy=0 same cycle; FWD_EN=0 -> old value that cycle, 1234 next cycle.
REQ-040 sb_set hart3 x9, next cycle rs1_busy=1; same-edge sb_set and writeback hart3 x9 -> busy stays 1; later writeback alone -> rs1_busy=0.
REQ-041 Write hart1 x4=32'hA5A5A5A5, assert rst_n low mid-cycle -> rs1_data=0 immediately, stays 0 after release.
